// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch-stage PC register with a 2-bit counter direction
// predictor and a tagged branch target buffer. Execute-stage resolution
// trains the tables and, on a mispredict, redirects fetch and raises flush.
// Optional macro PC_PREDICT_PERF_EN adds perf_branches / perf_mispredicts.
module pc_predict_unit #(
  parameter int           N         = 32,
  parameter logic [N-1:0] RESET_PC  = '0,
  parameter int           BHT_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  output logic [N-1:0] pc,
  output logic         pred_taken,
  output logic [N-1:0] pred_target,
  input  logic         res_valid,
  input  logic         res_is_branch,
  input  logic [N-1:0] res_pc,
  input  logic         res_taken,
  input  logic [N-1:0] res_target,
  input  logic         res_pred_taken,
  input  logic [N-1:0] res_pred_target,
`ifdef PC_PREDICT_PERF_EN
  output logic [31:0]  perf_branches,
  output logic [31:0]  perf_mispredicts,
`endif
  output logic         flush
);

  localparam int           IDX_W   = $clog2(BHT_DEPTH);
  localparam int           TAG_W   = N - IDX_W - 2;
  localparam logic [N-1:0] PC_STEP = N'(4);

  logic [1:0]           cnt_mem [BHT_DEPTH];
  logic [TAG_W-1:0]     tag_mem [BHT_DEPTH];
  logic [N-1:0]         tgt_mem [BHT_DEPTH];
  logic [BHT_DEPTH-1:0] valid_mem;

  logic [IDX_W-1:0] idx, res_idx;
  logic [TAG_W-1:0] tag, res_tag;
  logic             hit;
  logic             eff_taken;
  logic             mis;
  logic [N-1:0]     redirect_pc;

  assign idx     = pc[IDX_W+1:2];
  assign tag     = pc[N-1:IDX_W+2];
  assign res_idx = res_pc[IDX_W+1:2];
  assign res_tag = res_pc[N-1:IDX_W+2];

  // Zero-cycle prediction from the current PC and pre-update table contents.
  always_comb begin
    hit         = valid_mem[idx] && (tag_mem[idx] == tag);
    pred_taken  = hit && cnt_mem[idx][1];
    pred_target = pred_taken ? tgt_mem[idx] : pc + PC_STEP;
  end

  // Mispredict detection; jumps are always taken regardless of res_taken.
  always_comb begin
    eff_taken   = res_is_branch ? res_taken : 1'b1;
    mis         = res_valid &&
                  ((eff_taken != res_pred_taken) ||
                   (eff_taken && (res_target != res_pred_target)));
    flush       = mis && !rst;
    redirect_pc = eff_taken ? res_target : res_pc + PC_STEP;
  end

  // PC register: reset, then redirect (beats stall), then stall, then prediction.
  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (mis)
      pc <= redirect_pc;
    else if (!stall)
      pc <= pred_target;
  end

  // Counter and BTB training; not-taken branches never allocate a BTB entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        cnt_mem[i] <= 2'b01;
        tag_mem[i] <= '0;
        tgt_mem[i] <= '0;
      end
      valid_mem <= '0;
    end else if (res_valid) begin
      if (!res_is_branch || res_taken) begin
        valid_mem[res_idx] <= 1'b1;
        tag_mem[res_idx]   <= res_tag;
        tgt_mem[res_idx]   <= res_target;
      end
      if (!res_is_branch)
        cnt_mem[res_idx] <= 2'b11;
      else if (res_taken) begin
        if (cnt_mem[res_idx] != 2'b11)
          cnt_mem[res_idx] <= cnt_mem[res_idx] + 2'd1;
      end else begin
        if (cnt_mem[res_idx] != 2'b00)
          cnt_mem[res_idx] <= cnt_mem[res_idx] - 2'd1;
      end
    end
  end

`ifdef PC_PREDICT_PERF_EN
  // Saturating event counters for resolved branches and mispredicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (res_valid && res_is_branch && (perf_branches != '1))
        perf_branches <= perf_branches + 32'd1;
      if (mis && (perf_mispredicts != '1))
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit: directed vector table, hand-written corner sequences,
// and randomized stimulus checked against a table-level reference model.
module tb_pc_predict_unit;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] pc, pred_target;
  logic        pred_taken;
  logic        res_valid, res_is_branch, res_taken, res_pred_taken;
  logic [31:0] res_pc, res_target, res_pred_target;
  logic        flush;
`ifdef PC_PREDICT_PERF_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  int tests = 0;
  int fails = 0;

  pc_predict_unit #(.N(32), .RESET_PC(32'h400), .BHT_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_is_branch(res_is_branch), .res_pc(res_pc),
    .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
`ifdef PC_PREDICT_PERF_EN
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts),
`endif
    .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, v, br;
    logic [31:0] rpc;
    logic        tk;
    logic [31:0] rtgt;
    logic        rpt;
    logic [31:0] rptgt;
    logic        eflush, cpred, ept;
    logic [31:0] eptgt, epc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic v, input logic br,
                       input logic [31:0] rpc, input logic tk, input logic [31:0] rtgt,
                       input logic rpt, input logic [31:0] rptgt);
    rst = r; stall = s; res_valid = v; res_is_branch = br; res_pc = rpc;
    res_taken = tk; res_target = rtgt; res_pred_taken = rpt; res_pred_target = rptgt;
  endtask

  task automatic add(input logic r, input logic s, input logic v, input logic br,
                     input logic [31:0] rpc, input logic tk, input logic [31:0] rtgt,
                     input logic rpt, input logic [31:0] rptgt,
                     input logic ef, input logic cp, input logic ept,
                     input logic [31:0] eptgt, input logic [31:0] epc);
    vec_t t;
    t.rst = r; t.stall = s; t.v = v; t.br = br; t.rpc = rpc; t.tk = tk;
    t.rtgt = rtgt; t.rpt = rpt; t.rptgt = rptgt; t.eflush = ef; t.cpred = cp;
    t.ept = ept; t.eptgt = eptgt; t.epc = epc;
    vecs.push_back(t);
  endtask

  // Reference model state: counters as integers, BTB as plain arrays.
  int          cnt_m [16];
  bit          val_m [16];
  logic [31:0] tag_m [16];
  logic [31:0] tgt_m [16];
  logic [31:0] pc_m;
  longint      pb_m, pm_m;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      cnt_m[i] = 1; val_m[i] = 0; tag_m[i] = 0; tgt_m[i] = 0;
    end
    pc_m = 32'h400; pb_m = 0; pm_m = 0;
  endtask

  logic [31:0] pool [8] = '{32'h100, 32'h140, 32'h180, 32'h104,
                            32'h200, 32'h3004, 32'h3008, 32'h240};

  initial begin
    // rst stall v br rpc tk rtgt rpt rptgt | flush cpred ept eptgt | next pc
    add(1,0,1,1,32'h100,1,32'h200,0,32'h0,        0,0,0,32'h0,        32'h400);
    add(1,0,0,0,32'h0,0,32'h0,0,32'h0,            0,1,0,32'h404,      32'h400);
    add(0,0,0,0,32'h0,0,32'h0,0,32'h0,            0,1,0,32'h404,      32'h404);
    add(0,0,0,0,32'h0,0,32'h0,0,32'h0,            0,1,0,32'h408,      32'h408);
    add(0,1,0,0,32'h0,0,32'h0,0,32'h0,            0,1,0,32'h40C,      32'h408);
    add(0,1,0,0,32'h0,0,32'h0,0,32'h0,            0,1,0,32'h40C,      32'h408);
    add(0,1,0,0,32'h0,0,32'h0,0,32'h0,            0,1,0,32'h40C,      32'h408);
    add(0,0,0,0,32'h0,0,32'h0,0,32'h0,            0,1,0,32'h40C,      32'h40C);
    add(0,1,1,1,32'h100,1,32'h200,0,32'h0,        1,1,0,32'h410,      32'h200);
    add(0,0,1,1,32'h100,1,32'h200,1,32'h200,      0,1,0,32'h204,      32'h204);
    add(0,0,1,0,32'h3004,0,32'h100,0,32'h0,       1,0,0,32'h0,        32'h100);
    add(0,0,0,0,32'h0,0,32'h0,0,32'h0,            0,1,1,32'h200,      32'h200);
    add(0,0,1,1,32'h100,0,32'h200,1,32'h200,      1,1,0,32'h204,      32'h104);
    add(0,0,1,0,32'h3004,0,32'h100,0,32'h0,       1,0,0,32'h0,        32'h100);
    add(0,0,0,0,32'h0,0,32'h0,0,32'h0,            0,1,1,32'h200,      32'h200);
    add(0,0,1,0,32'h3004,0,32'h140,0,32'h0,       1,0,0,32'h0,        32'h140);
    add(0,0,0,0,32'h0,0,32'h0,0,32'h0,            0,1,0,32'h144,      32'h144);
    add(0,0,1,0,32'h140,0,32'h80,0,32'h0,         1,0,0,32'h0,        32'h80);
    add(0,0,1,0,32'h3004,0,32'h140,0,32'h0,       1,0,0,32'h0,        32'h140);
    add(0,0,0,0,32'h0,0,32'h0,0,32'h0,            0,1,1,32'h80,       32'h80);
    add(0,0,1,0,32'h3004,0,32'h140,1,32'h140,     0,1,0,32'h84,       32'h84);
    add(0,0,1,1,32'h3008,1,32'h500,1,32'h600,     1,0,0,32'h0,        32'h500);
    add(0,0,1,0,32'h500,0,32'h700,0,32'h0,        1,0,0,32'h0,        32'h700);
    add(0,0,1,0,32'h700,0,32'h900,1,32'h900,      0,1,0,32'h704,      32'h704);
    add(0,0,1,0,32'h3004,0,32'h700,0,32'h0,       1,0,0,32'h0,        32'h700);
    add(0,0,0,0,32'h0,0,32'h0,0,32'h0,            0,1,1,32'h900,      32'h900);
    add(0,0,1,0,32'h3004,0,32'hFFFF_FFFC,0,32'h0, 1,0,0,32'h0,        32'hFFFF_FFFC);
    add(0,0,0,0,32'h0,0,32'h0,0,32'h0,            0,1,0,32'h0,        32'h0);
    add(0,0,1,1,32'hFFFF_FFFC,0,32'h0,1,32'h123,  1,1,0,32'h4,        32'h0);

    drive(1,0,0,0,0,0,0,0,0);
    #1;
    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].stall, vecs[k].v, vecs[k].br, vecs[k].rpc,
            vecs[k].tk, vecs[k].rtgt, vecs[k].rpt, vecs[k].rptgt);
      #1;
      chk($sformatf("vec%0d flush", k), {31'b0, flush}, {31'b0, vecs[k].eflush});
      if (vecs[k].cpred) begin
        chk($sformatf("vec%0d pred_taken", k), {31'b0, pred_taken}, {31'b0, vecs[k].ept});
        chk($sformatf("vec%0d pred_target", k), pred_target, vecs[k].eptgt);
      end
      tick();
      chk($sformatf("vec%0d pc", k), pc, vecs[k].epc);
    end

    // Reset arriving during a redirect wins and clears the BTB.
    drive(1,0,1,0,32'h3004,0,32'h900,0,32'h0);
    #1;
    chk("rst_mid_redirect flush", {31'b0, flush}, 32'd0);
    tick();
    chk("rst_mid_redirect pc", pc, 32'h400);
    drive(0,0,1,0,32'h3004,0,32'h700,0,32'h0);
    tick();
    drive(0,0,0,0,0,0,0,0,0);
    #1;
    chk("post_rst btb cleared pred_taken", {31'b0, pred_taken}, 32'd0);
    chk("post_rst btb cleared pred_target", pred_target, 32'h704);

    // Randomized run against the reference model, starting from a reset.
    drive(1,0,0,0,0,0,0,0,0);
    tick();
    model_reset();
    for (int n = 0; n < 500; n++) begin
      logic        r, s, v, br, tk, rpt, ept, eff, mis, hit;
      logic [31:0] rpc, rtgt, rptgt, eptgt;
      int          i, ri;
      r   = ($urandom_range(0, 59) == 0);
      s   = ($urandom_range(0, 3) == 0);
      v   = $urandom_range(0, 1) == 1;
      br  = ($urandom_range(0, 9) < 7);
      tk  = $urandom_range(0, 1) == 1;
      rpc = pool[$urandom_range(0, 7)];
      rtgt = ($urandom_range(0, 4) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pool[$urandom_range(0, 7)];
      rpt = $urandom_range(0, 1) == 1;
      rptgt = ($urandom_range(0, 1) == 1) ? rtgt : pool[$urandom_range(0, 7)];
      drive(r, s, v, br, rpc, tk, rtgt, rpt, rptgt);

      i     = idx_of(pc_m);
      hit   = val_m[i] && (tag_m[i] == pc_m / 64);
      ept   = hit && (cnt_m[i] >= 2);
      eptgt = ept ? tgt_m[i] : pc_m + 32'd4;
      eff   = br ? tk : 1'b1;
      mis   = v && ((eff != rpt) || (eff && (rtgt != rptgt)));
      #1;
      chk("rand pred_taken", {31'b0, pred_taken}, {31'b0, ept});
      chk("rand pred_target", pred_target, eptgt);
      chk("rand flush", {31'b0, flush}, {31'b0, mis && !r});

      if (r) model_reset();
      else begin
        if (mis) pc_m = eff ? rtgt : rpc + 32'd4;
        else if (!s) pc_m = eptgt;
        if (v) begin
          ri = idx_of(rpc);
          if (!br) cnt_m[ri] = 3;
          else if (tk) cnt_m[ri] = (cnt_m[ri] < 3) ? cnt_m[ri] + 1 : 3;
          else cnt_m[ri] = (cnt_m[ri] > 0) ? cnt_m[ri] - 1 : 0;
          if (!br || tk) begin
            val_m[ri] = 1; tag_m[ri] = rpc / 64; tgt_m[ri] = rtgt;
          end
          if (br) pb_m++;
        end
        if (mis) pm_m++;
      end
      tick();
      chk("rand pc", pc, pc_m);
`ifdef PC_PREDICT_PERF_EN
      chk("rand perf_branches", perf_branches, 32'(pb_m));
      chk("rand perf_mispredicts", perf_mispredicts, 32'(pm_m));
`endif
    end

`ifdef PC_PREDICT_PERF_EN
    drive(1,0,0,0,0,0,0,0,0);
    tick();
    drive(0,0,1,1,32'h100,1,32'h200,1,32'h200);
    tick();
    drive(0,0,1,1,32'h104,0,32'h0,0,32'h0);
    tick();
    drive(0,0,1,1,32'h108,1,32'h300,0,32'h0);
    tick();
    drive(0,0,0,0,0,0,0,0,0);
    tick();
    chk("perf_branches after 3", perf_branches, 32'd3);
    chk("perf_mispredicts after 3", perf_mispredicts, 32'd1);
    drive(1,0,0,0,0,0,0,0,0);
    tick();
    chk("perf_branches rst", perf_branches, 32'd0);
    chk("perf_mispredicts rst", perf_mispredicts, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
